// File: rtl/gray_window_buffer_pkg.sv
// Shared types for the gray window stage: pixel width, pixel/window types and FSM states.
package gray_window_pkg;

    localparam int unsigned PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    // Element [8] is p00 (oldest row, left column), element [0] is p22 (newest pixel).
    typedef pixel_t [8:0] window_t;

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/gray_window_buffer_if.sv
// Pixel-in / window-out bundle of the gray window buffer.
// Optional pixel counter and overrun flag appear when GRAY_WINDOW_PIXCOUNT_EN is defined.
interface gray_window_buffer_if;
    import gray_window_pkg::*;

    logic    i_frame_start;
    logic    i_gray_valid;
    pixel_t  i_gray;
    window_t o_window;
    logic    o_window_valid;
    logic    o_frame_done;
`ifdef GRAY_WINDOW_PIXCOUNT_EN
    logic [31:0] o_pix_count;
    logic        o_overrun;

    modport master (
        output i_frame_start, i_gray_valid, i_gray,
        input  o_window, o_window_valid, o_frame_done, o_pix_count, o_overrun
    );
    modport slave (
        input  i_frame_start, i_gray_valid, i_gray,
        output o_window, o_window_valid, o_frame_done, o_pix_count, o_overrun
    );
`else
    modport master (
        output i_frame_start, i_gray_valid, i_gray,
        input  o_window, o_window_valid, o_frame_done
    );
    modport slave (
        input  i_frame_start, i_gray_valid, i_gray,
        output o_window, o_window_valid, o_frame_done
    );
`endif

endinterface

// File: rtl/gray_window_buffer_gray_line_fifo.sv
// Fixed-length pixel delay line: o_dout is the pixel shifted in DEPTH shifts ago.
module gray_line_fifo
    import gray_window_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic   clk,
    input  logic   i_shift,
    input  pixel_t i_din,
    output pixel_t o_dout
);

    pixel_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_shift) begin
            r_mem[0] <= i_din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/gray_window_buffer.sv
// Two-line buffer and 3x3 sliding window over a raster gray stream; one window per interior pixel.
// Optional feature: GRAY_WINDOW_PIXCOUNT_EN adds o_pix_count and o_overrun.
module gray_window_buffer
    import gray_window_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_window_buffer_if.slave  io_bus
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_col, w_col_next;
    logic [RW-1:0] r_row, w_row_next;
    window_t       r_window, w_window_next;
    logic          r_valid, w_valid_next;
    logic          r_done, w_done_next;
    pixel_t        w_lb1_out, w_lb2_out;
    logic          w_accept;

    assign w_accept = io_bus.i_gray_valid;

    gray_line_fifo #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk    (clk),
        .i_shift(w_accept),
        .i_din  (io_bus.i_gray),
        .o_dout (w_lb1_out)
    );

    gray_line_fifo #(.DEPTH(IMG_WIDTH)) u_lb2 (
        .clk    (clk),
        .i_shift(w_accept),
        .i_din  (w_lb1_out),
        .o_dout (w_lb2_out)
    );

    always_comb begin
        w_state_next  = r_state;
        w_col_next    = r_col;
        w_row_next    = r_row;
        w_window_next = r_window;
        w_valid_next  = 1'b0;
        w_done_next   = 1'b0;
        if (io_bus.i_frame_start) begin
            // A pixel arriving with the frame-start pulse becomes (0,0) of the new frame.
            w_state_next  = FILL;
            w_row_next    = '0;
            w_col_next    = w_accept ? CW'(1) : '0;
            w_window_next = '0;
        end else if (w_accept) begin
            w_window_next = {r_window[7:6], w_lb2_out,
                             r_window[4:3], w_lb1_out,
                             r_window[1:0], io_bus.i_gray};
            w_valid_next  = (r_state == ACTIVE) && (r_col >= CW'(2));
            if (r_col == COL_LAST) begin
                w_col_next = '0;
                if (r_state == FILL) begin
                    if (r_row == RW'(1)) w_state_next = ACTIVE;
                    w_row_next = r_row + RW'(1);
                end else if (r_row == ROW_LAST) begin
                    w_state_next = FILL;
                    w_row_next   = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_row_next = r_row + RW'(1);
                end
            end else begin
                w_col_next = r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FILL;
            r_col    <= '0;
            r_row    <= '0;
            r_window <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_col    <= w_col_next;
            r_row    <= w_row_next;
            r_window <= w_window_next;
            r_valid  <= w_valid_next;
            r_done   <= w_done_next;
        end
    end

    assign io_bus.o_window       = r_window;
    assign io_bus.o_window_valid = r_valid;
    assign io_bus.o_frame_done   = r_done;

`ifdef GRAY_WINDOW_PIXCOUNT_EN
    logic [31:0] r_pix_count;
    logic        r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_count <= '0;
        end else if (io_bus.i_frame_start) begin
            r_pix_count <= w_accept ? 32'd1 : '0;
        end else if (w_accept) begin
            r_pix_count <= r_pix_count + 32'd1;
        end
    end

    // Sticky across rst itself; only a frame start outside reset clears it.
    always_ff @(posedge clk) begin
        if (rst && w_accept) begin
            r_overrun <= 1'b1;
        end else if (!rst && io_bus.i_frame_start) begin
            r_overrun <= 1'b0;
        end
    end

    assign io_bus.o_pix_count = r_pix_count;
    assign io_bus.o_overrun   = r_overrun;
`endif

endmodule
